// File: rtl/buffer_array_pingpong_if.sv
// Handshake/data bundle for buffer_array_pingpong: input beat stream in,
// completed window out.
interface buffer_array_pingpong_if #(
  parameter int unsigned IDIM = 4,
  parameter int unsigned IWID = 1,
  parameter int unsigned OWID = 32,
  parameter int unsigned CWID = 16
);
  logic [CWID-1:0]      iLen;
  logic                 iValid;
  logic                 oReady;
  logic                 iAccSel;
  logic                 iClear;
  logic [IDIM*IWID-1:0] iData;
  logic                 oValid;
  logic                 iReady;
  logic [IDIM*OWID-1:0] oData;
  logic [IDIM-1:0]      oSat;

  modport master (
    output iLen, iValid, iAccSel, iClear, iData, iReady,
    input  oReady, oValid, oData, oSat
  );

  modport slave (
    input  iLen, iValid, iAccSel, iClear, iData, iReady,
    output oReady, oValid, oData, oSat
  );
endinterface

// File: rtl/buffer_array_pingpong.sv
// Per-channel saturating window accumulator with a ping-pong bank pair:
// one bank accumulates while the other presents the last completed window.
module buffer_array_pingpong #(
  parameter int unsigned IDIM = 4,
  parameter int unsigned IWID = 1,
  parameter int unsigned OWID = 32,
  parameter int unsigned CWID = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  buffer_array_pingpong_if.slave   bus
);

  if (IWID > OWID) begin : g_width_check
    $error("buffer_array_pingpong: IWID must not exceed OWID");
  end

  typedef enum logic {EMPTY, HELD} state_t;

  state_t          state, state_nxt;
  logic            act;
  logic            held_sel;
  logic [OWID-1:0] bank [2][IDIM];
  logic [IDIM-1:0] sat  [2];
  logic [CWID-1:0] cnt, len_q, len_eff;
  logic            last, stall, accept, complete, transfer;
  logic [OWID:0]   sum_w   [IDIM];
  logic [OWID-1:0] upd     [IDIM];
  logic [IDIM-1:0] upd_sat;

  // While cnt==0 the window length is taken straight from iLen so a 1-beat
  // window compares against the length being loaded this cycle.
  always_comb begin
    if (cnt == '0) len_eff = (bus.iLen == '0) ? CWID'(1) : bus.iLen;
    else           len_eff = len_q;
    last       = (cnt == len_eff - CWID'(1));
    transfer   = (state == HELD) && bus.iReady;
    stall      = last && (state == HELD) && !bus.iReady;
    bus.oReady = !bus.iClear && !stall;
    accept     = bus.iValid && bus.oReady;
    complete   = accept && last;
    held_sel   = ~act;
  end

  always_comb begin
    upd_sat = sat[act];
    for (int unsigned c = 0; c < IDIM; c++) begin
      sum_w[c] = {1'b0, bank[act][c]}
               + {{(OWID+1-IWID){1'b0}}, bus.iData[c*IWID +: IWID]};
      if (!bus.iAccSel) begin
        upd[c] = OWID'(bus.iData[c*IWID +: IWID]);
      end else if (sum_w[c][OWID]) begin
        upd[c]     = '1;
        upd_sat[c] = 1'b1;
      end else begin
        upd[c] = sum_w[c][OWID-1:0];
      end
    end
  end

  // On completion the pointer flips: the finished bank becomes the held one
  // and the previously held (already drained) bank is zeroed for reuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        sat[b] <= '0;
        for (int unsigned c = 0; c < IDIM; c++) bank[b][c] <= '0;
      end
    end else begin
      if (cnt == '0) len_q <= len_eff;
      if (bus.iClear) begin
        cnt      <= '0;
        sat[act] <= '0;
        for (int unsigned c = 0; c < IDIM; c++) bank[act][c] <= '0;
      end else if (complete) begin
        cnt           <= '0;
        act           <= ~act;
        sat[act]      <= upd_sat;
        sat[held_sel] <= '0;
        for (int unsigned c = 0; c < IDIM; c++) begin
          bank[act][c]      <= upd[c];
          bank[held_sel][c] <= '0;
        end
      end else if (accept) begin
        cnt      <= cnt + CWID'(1);
        sat[act] <= upd_sat;
        for (int unsigned c = 0; c < IDIM; c++) bank[act][c] <= upd[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (complete) state_nxt = HELD;
      HELD:    if (transfer && !complete) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    bus.oValid = (state == HELD);
    bus.oSat   = sat[held_sel];
    bus.oData  = '0;
    for (int unsigned c = 0; c < IDIM; c++) bus.oData[c*OWID +: OWID] = bank[held_sel][c];
  end

endmodule

// File: tb/tb_buffer_array_pingpong.sv
// Bench: an 8-bit and a 4-bit accumulator instance share one stimulus stream
// and are checked against a window-level scoreboard plus directed vectors.
module tb_buffer_array_pingpong;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_array_pingpong_if #(.IDIM(4), .IWID(1), .OWID(8), .CWID(16)) b8 ();
  buffer_array_pingpong_if #(.IDIM(4), .IWID(1), .OWID(4), .CWID(16)) b4 ();

  assign b4.iLen    = b8.iLen;
  assign b4.iValid  = b8.iValid;
  assign b4.iAccSel = b8.iAccSel;
  assign b4.iClear  = b8.iClear;
  assign b4.iData   = b8.iData;
  assign b4.iReady  = b8.iReady;

  buffer_array_pingpong #(.IDIM(4), .IWID(1), .OWID(8), .CWID(16)) dut8 (
    .clk(clk), .rst(rst), .bus(b8));
  buffer_array_pingpong #(.IDIM(4), .IWID(1), .OWID(4), .CWID(16)) dut4 (
    .clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [31:0] d8;
    logic [15:0] d4;
    logic [3:0]  s8;
    logic [3:0]  s4;
  } win_t;

  typedef struct {
    logic        v, a, c;
    logic [3:0]  d;
    logic        r;
    logic [15:0] l;
    logic        e_ready, e_valid;
    logic [31:0] e_d8;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: running sums per channel, beats in window, and the
  // list of completed windows not yet taken downstream
  win_t        q[$];
  int unsigned m_acc8[4], m_acc4[4];
  logic [3:0]  m_sat8, m_sat4;
  int          m_beats, m_win;

  logic        s_ready, s_valid;
  logic [31:0] s_d8;
  logic [15:0] s_d4;
  logic [3:0]  s_s8, s_s4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < 4; c++) begin m_acc8[c] = 0; m_acc4[c] = 0; end
    m_sat8 = '0; m_sat4 = '0; m_beats = 0; m_win = 1;
  endtask

  task automatic step(input logic v, input logic a, input logic c, input logic [3:0] d,
                      input logic r, input logic [15:0] l);
    logic xr, xfer;
    win_t w;
    @(negedge clk);
    b8.iValid = v; b8.iAccSel = a; b8.iClear = c; b8.iData = d; b8.iReady = r; b8.iLen = l;
    #1;
    s_ready = b8.oReady; s_valid = b8.oValid; s_d8 = b8.oData; s_d4 = b4.oData;
    s_s8 = b8.oSat; s_s4 = b4.oSat;
    if (m_beats == 0) m_win = (l == 0) ? 1 : int'(l);
    xr = !c && !(m_beats == m_win - 1 && q.size() > 0 && !r);
    chk("ready8", s_ready, xr);
    chk("ready4", b4.oReady, xr);
    chk("valid8", s_valid, q.size() > 0);
    chk("valid4", b4.oValid, q.size() > 0);
    if (q.size() > 0) begin
      chk("data8", s_d8, q[0].d8);
      chk("data4", s_d4, q[0].d4);
      chk("sat8", s_s8, q[0].s8);
      chk("sat4", s_s4, q[0].s4);
    end
    xfer = (q.size() > 0) && r;
    if (xfer) void'(q.pop_front());
    if (c) begin
      for (int i = 0; i < 4; i++) begin m_acc8[i] = 0; m_acc4[i] = 0; end
      m_sat8 = '0; m_sat4 = '0; m_beats = 0;
    end else if (v && xr) begin
      for (int i = 0; i < 4; i++) begin
        if (a) begin
          if (m_acc8[i] + d[i] > 255) begin m_acc8[i] = 255; m_sat8[i] = 1'b1; end
          else m_acc8[i] = m_acc8[i] + d[i];
          if (m_acc4[i] + d[i] > 15) begin m_acc4[i] = 15; m_sat4[i] = 1'b1; end
          else m_acc4[i] = m_acc4[i] + d[i];
        end else begin
          m_acc8[i] = d[i]; m_acc4[i] = d[i];
        end
      end
      m_beats++;
      if (m_beats == m_win) begin
        for (int i = 0; i < 4; i++) begin
          w.d8[i*8 +: 8] = 8'(m_acc8[i]);
          w.d4[i*4 +: 4] = 4'(m_acc4[i]);
          m_acc8[i] = 0; m_acc4[i] = 0;
        end
        w.s8 = m_sat8; w.s4 = m_sat4;
        q.push_back(w);
        m_sat8 = '0; m_sat4 = '0; m_beats = 0;
      end
    end
  endtask

  vec_t tbl[9];
  int   lows, pulses;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 16'd4, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 16'd4, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 16'd4, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 16'd4, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd4, 1'b1, 1'b1, 32'h00010001};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd4, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 16'd0, 1'b1, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd0, 1'b1, 1'b1, 32'h01010101};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd0, 1'b1, 1'b0, 32'h0};

    b8.iValid = 0; b8.iAccSel = 1; b8.iClear = 0; b8.iData = '0; b8.iReady = 1; b8.iLen = 16'd4;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", b8.oValid, 1'b0);
    chk("reset_data8", b8.oData, 32'h0);
    chk("reset_sat4", b4.oSat, 4'h0);
    @(negedge clk); rst = 1'b0;

    // overwrite on the last beat, then a zero-length (treated as 1) window
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].l);
      chk("tbl_ready", s_ready, tbl[i].e_ready);
      chk("tbl_valid", s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk("tbl_data8", s_d8, tbl[i].e_d8);
    end

    // continuous 16-beat windows with downstream always ready
    lows = 0; pulses = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, 1, 0, 4'b1111, 1, 16'd16);
      if (!s_ready) lows++;
      if (s_valid) begin
        pulses++;
        chk("t1_data8", s_d8, 32'h10101010);
        chk("t1_sat8", s_s8, 4'h0);
      end
    end
    chk("t1_ready_low_count", lows, 0);
    chk("t1_window_count", pulses, 2);
    step(0, 1, 0, 4'b0000, 1, 16'd16);

    // 4-bit counters clip on a 20-beat window, then a clean 10-beat window
    for (int i = 0; i < 20; i++) step(1, 1, 0, 4'b1111, 1, 16'd20);
    step(0, 1, 0, 4'b0000, 1, 16'd10);
    chk("t3_data4_sat", s_d4, 16'hFFFF);
    chk("t3_sat4", s_s4, 4'hF);
    chk("t3_data8", s_d8, 32'h14141414);
    chk("t3_sat8", s_s8, 4'h0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 4'b1111, 1, 16'd10);
    step(0, 1, 0, 4'b0000, 1, 16'd10);
    chk("t3_data4_next", s_d4, 16'hAAAA);
    chk("t3_sat4_next", s_s4, 4'h0);

    // held window blocks only the completing beat of the next window
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4'b1111, 0, 16'd4);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 4'b0011, 0, 16'd4);
      chk("t4_early_ready", s_ready, 1'b1);
      chk("t4_held_data", s_d8, 32'h04040404);
    end
    step(1, 1, 0, 4'b0011, 0, 16'd4);
    chk("t4_stall", s_ready, 1'b0);
    step(1, 1, 0, 4'b0011, 1, 16'd4);
    chk("t4_release_ready", s_ready, 1'b1);
    chk("t4_first_data", s_d8, 32'h04040404);
    step(0, 1, 0, 4'b0000, 0, 16'd4);
    chk("t4_second_valid", s_valid, 1'b1);
    chk("t4_second_data", s_d8, 32'h00000404);
    step(0, 1, 0, 4'b0000, 1, 16'd4);
    step(0, 1, 0, 4'b0000, 1, 16'd4);
    chk("t4_drained", s_valid, 1'b0);

    // clear mid-window drops the coincident beat and spares the held bank
    for (int i = 0; i < 8; i++) step(1, 1, 0, 4'b1111, 0, 16'd8);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 4'b1111, 0, 16'd8);
    step(1, 1, 1, 4'b1111, 0, 16'd8);
    chk("t5_clear_ready", s_ready, 1'b0);
    step(0, 1, 0, 4'b0000, 0, 16'd8);
    chk("t5_held_valid", s_valid, 1'b1);
    chk("t5_held_data", s_d8, 32'h08080808);
    step(0, 1, 0, 4'b0000, 1, 16'd8);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 4'b1000, 1, 16'd8);
    step(0, 1, 0, 4'b0000, 1, 16'd8);
    chk("t5_after_clear", s_d8, 32'h08000000);

    // asynchronous reset while a window is presented
    for (int i = 0; i < 6; i++) step(1, 1, 0, 4'b1111, 0, 16'd4);
    chk("t6_pre_valid", s_valid, 1'b1);
    @(negedge clk);
    b8.iValid = 0;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", b8.oValid, 1'b0);
    chk("t6_rst_data8", b8.oData, 32'h0);
    chk("t6_rst_data4", b4.oData, 16'h0);
    chk("t6_rst_sat", b4.oSat, 4'h0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4'b1111, 1, 16'd4);
    step(0, 1, 0, 4'b0000, 1, 16'd4);
    chk("t6_first_window", s_d8, 32'h04040404);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
           4'($urandom), $urandom_range(0, 2) != 0,
           ($urandom_range(0, 3) == 0) ? 16'($urandom_range(14, 20)) : 16'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
